exe_stage: RTL and testbench
============================

EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 The block SHALL have port ID_to_EXE_valid  input  1  decode bundle valid.
REQ-004 The block SHALL have port EXE_signal  input  158  decode bundle laid out as follows: pc[157:126], rf_we[125], rf_waddr[124:120], rkd_value[119:88], res_from_mem[87], mem_we[86:83], alu_op[82:64] (one-hot), alu_src1[63:32], alu_src2[31:0].
REQ-005 The block SHALL have port MEM_allowin  input  1  downstream stage can accept.
REQ-006 The block SHALL have port EXE_allowin  output  1  EXE can accept a new bundle this cycle.
REQ-007 The block SHALL have port MEM_signal_valid  output  1  MEM_signal valid.
REQ-008 The block SHALL have port MEM_signal  output  71  laid out as follows: pc[70:39], rf_we[38], rf_waddr[37:33], res_from_mem[32], result[31:0].
REQ-009 The block SHALL have port data_sram_en  output  1  data SRAM request.
REQ-010 The block SHALL have port data_sram_we  output  4  byte write enables.
REQ-011 The block SHALL have port data_sram_addr  output  32  address, equal to the ALU result.
REQ-012 The block SHALL have port data_sram_wdata  output  32  store data, equal to the latched rkd_value.
REQ-013 The block SHALL have port EXE_fwd  output  38  forwarding/hazard info laid out as follows: {EXE_valid&rf_we, rf_waddr, result}.
REQ-014 The block SHALL have port EXE_fwd_ready  output  1  EXE_fwd result is final.
REQ-015 The block SHALL have port EXE_is_load  output  1  EXE_valid & res_from_mem, used for load-use hazard detection.

Function
REQ-016 The pipeline register SHALL be updated with EXE_valid<=ID_to_EXE_valid whenever EXE_allowin=1, and the bundle SHALL be latched only when ID_to_EXE_valid&EXE_allowin.
REQ-017 EXE_readygo SHALL be !is_div | div_done, where is_div = |alu_op[18:15]; EXE_allowin SHALL be !EXE_valid | (EXE_readygo & MEM_allowin).
REQ-018 MEM_signal_valid SHALL be EXE_valid&EXE_readygo, and EXE_fwd_ready SHALL be EXE_readygo.
REQ-019 The ALU SHALL be combinational and implement the following alu_op bits: 0 add, 1 sub, 2 signed slt, 3 unsigned sltu, 4 and, 5 nor, 6 or, 7 xor, 8 sll, 9 srl, 10 sra (shift amount src2[4:0]), 11 result=src2.
REQ-020 The multiply ops SHALL be single-cycle: alu_op 12 (mul) returns the low 32 bits, 13 (mulh) the high 32 bits signed, and 14 (mulhu) the high 32 bits unsigned, each from a 64-bit product.
REQ-021 The divide ops SHALL be 15 div, 16 divu, 17 mod and 18 modu, computed by an iterative radix-2 restoring divider operating on operand magnitudes.
REQ-022 The divider FSM SHALL have states IDLE->BUSY->DONE->IDLE: IDLE->BUSY in the first EXE cycle of a valid div op, with operands captured; BUSY SHALL last exactly 32 cycles, one quotient bit per cycle; DONE SHALL hold until EXE_allowin, then return to IDLE.
REQ-023 Divide latency SHALL be: instruction enters EXE at cycle 0 and MEM_signal_valid asserts at cycle 33.
REQ-024 Signed quotient sign SHALL be sign(a)^sign(b) and signed remainder sign SHALL be sign(a); 0x80000000 / -1 SHALL give quotient 0x80000000 and remainder 0.
REQ-025 Divide-by-zero SHALL give quotient 0xFFFFFFFF and remainder = dividend, with the same 33-cycle latency.
REQ-026 data_sram_en SHALL be EXE_valid & MEM_allowin & (res_from_mem | |mem_we), and data_sram_we SHALL be mem_we & {4{data_sram_en}}, so no duplicate request is issued while stalled.
REQ-027 When MEM_allowin=0, all latched fields and divider state SHALL hold.
REQ-028 A divide stalled in DONE SHALL NOT restart.

Reset
REQ-029 On reset, EXE_valid SHALL be 0, the divider state IDLE, and all pipeline-register fields 0; consequently all outputs SHALL be 0 except EXE_allowin=1 and EXE_fwd_ready=1.
REQ-030 Reset asserted mid-divide SHALL abort immediately, with no MEM_signal_valid emitted afterwards.

Structure
REQ-031 A shared package SHALL hold the bundle widths (158, 71, 38), the alu_op bit indices 0..18, and the divider state encoding.
REQ-032 The divider SHALL be one sub-module, exe_div, with ports start, signed_op, a, b, busy, done, quotient and remainder; the ALU SHALL be inline.

Verification
REQ-033 The bench SHALL apply add with src1=5, src2=7 and MEM_allowin=1 -> MEM_signal result 12 one cycle after acceptance.
REQ-034 The bench SHALL apply div with src1=-7, src2=2 -> quotient 0xFFFFFFFD, EXE_allowin=0 for cycles 0..32, and valid at cycle 33; mod with the same operands -> 0xFFFFFFFF.
REQ-035 The bench SHALL apply divu with src2=0 and src1=0x1234 -> quotient 0xFFFFFFFF; modu with the same operands -> 0x1234.
REQ-036 The bench SHALL issue st with mem_we=0xF while holding MEM_allowin=0 for 3 cycles -> data_sram_en=0 during the stall, then exactly one request with we=0xF.
REQ-037 The bench SHALL assert reset at BUSY cycle 10 -> after release EXE_allowin=1, MEM_signal_valid=0, and the next add completes normally.
REQ-038 The bench SHALL apply mulh with src1=0x80000000, src2=2 -> result 0xFFFFFFFF; mulhu with the same operands -> 0x00000001.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: bundle layouts, ALU opcode bit
// positions and the divider state encoding.
package exe_pkg;

  localparam int EXE_SIG_W = 158;
  localparam int MEM_SIG_W = 71;
  localparam int FWD_W     = 38;
  localparam int ALU_OP_W  = 19;

  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_SLT   = 2;
  localparam int OP_SLTU  = 3;
  localparam int OP_AND   = 4;
  localparam int OP_NOR   = 5;
  localparam int OP_OR    = 6;
  localparam int OP_XOR   = 7;
  localparam int OP_SLL   = 8;
  localparam int OP_SRL   = 9;
  localparam int OP_SRA   = 10;
  localparam int OP_LUI   = 11;
  localparam int OP_MUL   = 12;
  localparam int OP_MULH  = 13;
  localparam int OP_MULHU = 14;
  localparam int OP_DIV   = 15;
  localparam int OP_DIVU  = 16;
  localparam int OP_MOD   = 17;
  localparam int OP_MODU  = 18;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Field order matches the packed bit layout, MSB first.
  typedef struct packed {
    logic [31:0]         pc;
    logic                rf_we;
    logic [4:0]          rf_waddr;
    logic [31:0]         rkd_value;
    logic                res_from_mem;
    logic [3:0]          mem_we;
    logic [ALU_OP_W-1:0] alu_op;
    logic [31:0]         alu_src1;
    logic [31:0]         alu_src2;
  } exe_bundle_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        res_from_mem;
    logic [31:0] result;
  } mem_bundle_t;

endpackage

// File: rtl/exe_div.sv
// Iterative radix-2 restoring divider on operand magnitudes; one quotient bit
// per BUSY cycle, result held in DONE until acknowledged.
module exe_div
  import exe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ack,
  input  logic        stall,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_e  state, state_next;
  logic [4:0]  cnt;
  logic [31:0] rem_q, quo_q, dsr_q;
  logic        q_neg, r_neg, div_zero;

  logic [31:0] a_mag, b_mag;
  logic [32:0] rem_shift, rem_diff;
  logic        fits;

  assign a_mag = (signed_op && a[31]) ? -a : a;
  assign b_mag = (signed_op && b[31]) ? -b : b;

  assign rem_shift = {rem_q, quo_q[31]};
  assign rem_diff  = rem_shift - {1'b0, dsr_q};
  assign fits      = rem_shift >= {1'b0, dsr_q};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= DIV_IDLE;
    else       state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      DIV_IDLE: if (start) state_next = DIV_BUSY;
      DIV_BUSY: if (!stall && cnt == 5'd31) state_next = DIV_DONE;
      DIV_DONE: if (ack) state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
    end else if (state == DIV_IDLE && start) begin
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= a_mag;
      dsr_q    <= b_mag;
      q_neg    <= signed_op & (a[31] ^ b[31]);
      r_neg    <= signed_op & a[31];
      div_zero <= (b == 32'd0);
    end else if (state == DIV_BUSY && !stall) begin
      cnt   <= cnt + 5'd1;
      rem_q <= fits ? rem_diff[31:0] : rem_shift[31:0];
      quo_q <= {quo_q[30:0], fits};
    end
  end

  // Divide-by-zero naturally yields remainder = |a| but needs an all-ones quotient.
  assign quotient  = div_zero ? 32'hFFFF_FFFF : (q_neg ? -quo_q : quo_q);
  assign remainder = r_neg ? -rem_q : rem_q;
  assign busy      = (state == DIV_BUSY);
  assign done      = (state == DIV_DONE);

endmodule

// File: rtl/exe_stage.sv
// Execute stage: pipeline register, single-cycle ALU/multiplier and an
// iterative divider, with data SRAM request and forwarding outputs.
module exe_stage
  import exe_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ID_to_EXE_valid,
  input  logic [EXE_SIG_W-1:0] EXE_signal,
  input  logic                 MEM_allowin,
  output logic                 EXE_allowin,
  output logic                 MEM_signal_valid,
  output logic [MEM_SIG_W-1:0] MEM_signal,
  output logic                 data_sram_en,
  output logic [3:0]           data_sram_we,
  output logic [31:0]          data_sram_addr,
  output logic [31:0]          data_sram_wdata,
  output logic [FWD_W-1:0]     EXE_fwd,
  output logic                 EXE_fwd_ready,
  output logic                 EXE_is_load
);

  logic                exe_valid;
  exe_bundle_t         bundle;
  logic [ALU_OP_W-1:0] op;
  logic [31:0]         src1, src2;
  logic [31:0]         alu_result, exe_result;
  logic signed [31:0]  sra_res;
  logic [63:0]         prod_s;
  logic [31:0]         mulhu_res;
  logic                is_div, readygo;
  logic                div_start, div_busy, div_done;
  logic [31:0]         quotient, remainder;
  mem_bundle_t         mem_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exe_valid <= 1'b0;
      bundle    <= '0;
    end else if (EXE_allowin) begin
      exe_valid <= ID_to_EXE_valid;
      if (ID_to_EXE_valid) bundle <= exe_bundle_t'(EXE_signal);
    end
  end

  assign op   = bundle.alu_op;
  assign src1 = bundle.alu_src1;
  assign src2 = bundle.alu_src2;

  assign sra_res = $signed(src1) >>> src2[4:0];
  assign prod_s  = $signed({{32{src1[31]}}, src1}) * $signed({{32{src2[31]}}, src2});
  // Unsigned high word derived from the signed product to share one multiplier.
  assign mulhu_res = prod_s[63:32] + (src1[31] ? src2 : 32'd0) + (src2[31] ? src1 : 32'd0);

  always_comb begin
    alu_result = '0;
    if (op[OP_ADD])   alu_result = src1 + src2;
    if (op[OP_SUB])   alu_result = src1 - src2;
    if (op[OP_SLT])   alu_result = {31'd0, $signed(src1) < $signed(src2)};
    if (op[OP_SLTU])  alu_result = {31'd0, src1 < src2};
    if (op[OP_AND])   alu_result = src1 & src2;
    if (op[OP_NOR])   alu_result = ~(src1 | src2);
    if (op[OP_OR])    alu_result = src1 | src2;
    if (op[OP_XOR])   alu_result = src1 ^ src2;
    if (op[OP_SLL])   alu_result = src1 << src2[4:0];
    if (op[OP_SRL])   alu_result = src1 >> src2[4:0];
    if (op[OP_SRA])   alu_result = sra_res;
    if (op[OP_LUI])   alu_result = src2;
    if (op[OP_MUL])   alu_result = prod_s[31:0];
    if (op[OP_MULH])  alu_result = prod_s[63:32];
    if (op[OP_MULHU]) alu_result = mulhu_res;
  end

  assign is_div    = |op[OP_MODU:OP_DIV];
  assign div_start = exe_valid & is_div & MEM_allowin & ~div_busy & ~div_done;

  exe_div u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .ack       (EXE_allowin),
    .stall     (~MEM_allowin),
    .signed_op (op[OP_DIV] | op[OP_MOD]),
    .a         (src1),
    .b         (src2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  assign exe_result = !is_div ? alu_result :
                      (op[OP_MOD] | op[OP_MODU]) ? remainder : quotient;

  assign readygo          = ~is_div | div_done;
  assign EXE_allowin      = ~exe_valid | (readygo & MEM_allowin);
  assign MEM_signal_valid = exe_valid & readygo;
  assign EXE_fwd_ready    = readygo;

  assign mem_out.pc           = bundle.pc;
  assign mem_out.rf_we        = bundle.rf_we;
  assign mem_out.rf_waddr     = bundle.rf_waddr;
  assign mem_out.res_from_mem = bundle.res_from_mem;
  assign mem_out.result       = exe_result;
  assign MEM_signal           = mem_out;

  // Gating on MEM_allowin keeps a stalled access from being re-issued.
  assign data_sram_en    = exe_valid & MEM_allowin & (bundle.res_from_mem | (|bundle.mem_we));
  assign data_sram_we    = bundle.mem_we & {4{data_sram_en}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = bundle.rkd_value;

  assign EXE_fwd     = {exe_valid & bundle.rf_we, bundle.rf_waddr, exe_result};
  assign EXE_is_load = exe_valid & bundle.res_from_mem;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed corner cases plus randomized
// traffic compared every cycle against a behavioural model.
module tb_exe_stage;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         id_valid = 1'b0;
  logic [157:0] exe_signal = '0;
  logic         mem_allowin = 1'b1;

  logic         EXE_allowin, MEM_signal_valid, data_sram_en, EXE_fwd_ready, EXE_is_load;
  logic [70:0]  MEM_signal;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr, data_sram_wdata;
  logic [37:0]  EXE_fwd;

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  exe_stage dut (
    .clk              (clk),
    .reset            (reset),
    .ID_to_EXE_valid  (id_valid),
    .EXE_signal       (exe_signal),
    .MEM_allowin      (mem_allowin),
    .EXE_allowin      (EXE_allowin),
    .MEM_signal_valid (MEM_signal_valid),
    .MEM_signal       (MEM_signal),
    .data_sram_en     (data_sram_en),
    .data_sram_we     (data_sram_we),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata),
    .EXE_fwd          (EXE_fwd),
    .EXE_fwd_ready    (EXE_fwd_ready),
    .EXE_is_load      (EXE_is_load)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result of one operation, straight from the op definitions.
  function automatic logic [31:0] ref_result(input logic [18:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa = a;
    int sb = b;
    longint p;
    logic [63:0] pu;
    p  = longint'(sa) * longint'(sb);
    pu = {32'd0, a} * {32'd0, b};
    if (op[0])  return a + b;
    if (op[1])  return a - b;
    if (op[2])  return (sa < sb) ? 32'd1 : 32'd0;
    if (op[3])  return (a < b) ? 32'd1 : 32'd0;
    if (op[4])  return a & b;
    if (op[5])  return ~(a | b);
    if (op[6])  return a | b;
    if (op[7])  return a ^ b;
    if (op[8])  return a << b[4:0];
    if (op[9])  return a >> b[4:0];
    if (op[10]) return sa >>> b[4:0];
    if (op[11]) return b;
    if (op[12]) return p[31:0];
    if (op[13]) return p[63:32];
    if (op[14]) return pu[63:32];
    if (op[15]) begin
      if (b == 0) return 32'hFFFF_FFFF;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
      return sa / sb;
    end
    if (op[16]) return (b == 0) ? 32'hFFFF_FFFF : a / b;
    if (op[17]) begin
      if (b == 0) return a;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
      return sa % sb;
    end
    if (op[18]) return (b == 0) ? a : a % b;
    return 32'd0;
  endfunction

  function automatic logic [157:0] make_bundle(input int opi, input logic [31:0] a,
      input logic [31:0] b, input logic [31:0] pc, input logic we, input logic [4:0] waddr,
      input logic [31:0] rkd, input logic rfm, input logic [3:0] mwe);
    logic [18:0] op;
    op = '0;
    op[opi] = 1'b1;
    return {pc, we, waddr, rkd, rfm, mwe, op, a, b};
  endfunction

  // Model: what sits in EXE, and for a divide how many unstalled cycles it has
  // spent there (the result is final after 33 of them).
  logic         m_valid = 1'b0;
  logic [157:0] m_bundle = '0;
  int           m_prog = 0;

  wire        m_is_div = |m_bundle[82:79];
  wire        m_rdy    = !m_is_div || (m_prog >= 33);
  wire        m_alw    = !m_valid || (m_rdy && mem_allowin);
  wire [31:0] m_res    = ref_result(m_bundle[82:64], m_bundle[63:32], m_bundle[31:0]);
  wire        m_en     = m_valid && mem_allowin && (m_bundle[87] || m_bundle[86:83] != 4'd0);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid  <= 1'b0;
      m_bundle <= '0;
      m_prog   <= 0;
    end else begin
      if (m_valid && m_is_div && mem_allowin && m_prog < 33) m_prog <= m_prog + 1;
      if (m_alw) begin
        m_valid <= id_valid;
        if (id_valid) m_bundle <= exe_signal;
        m_prog <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("allowin", EXE_allowin, m_alw);
      check("mem_valid", MEM_signal_valid, m_valid & m_rdy);
      check("fwd_ready", EXE_fwd_ready, m_rdy);
      check("fwd_we", EXE_fwd[37], m_valid & m_bundle[125]);
      check("is_load", EXE_is_load, m_valid & m_bundle[87]);
      check("sram_en", data_sram_en, m_en);
      check("sram_we", data_sram_we, m_bundle[86:83] & {4{m_en}});
      if (m_valid && m_rdy) begin
        check("mem_signal", MEM_signal,
              {m_bundle[157:126], m_bundle[125], m_bundle[124:120], m_bundle[87], m_res});
        check("fwd_data", EXE_fwd[36:0], {m_bundle[124:120], m_res});
      end
      if (m_en) begin
        check("sram_addr", data_sram_addr, m_res);
        check("sram_wdata", data_sram_wdata, m_bundle[119:88]);
      end
    end
  end

  // Issue one op into an empty EXE and wait for its result.
  task automatic run_op(input string name, input int opi, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    bit seen = 1'b0;
    int lat = 0;
    logic [31:0] got = '0;
    mem_allowin = 1'b1;
    id_valid    = 1'b1;
    exe_signal  = make_bundle(opi, a, b, 32'h1C00_0040, 1'b1, 5'd4, 32'h0, 1'b0, 4'h0);
    @(posedge clk); #1;
    id_valid = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (MEM_signal_valid) begin
        seen = 1'b1;
        lat  = n;
        got  = MEM_signal[31:0];
        break;
      end
      check({name, "_hold"}, EXE_allowin, 1'b0);
      @(posedge clk); #1;
    end
    check({name, "_seen"}, seen, 1'b1);
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_res"}, got, exp_res);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int reqs;
    int late_valid;
    #2 reset = 1'b1;
    armed = 1'b1;
    @(negedge clk);
    check("rst_allowin", EXE_allowin, 1'b1);
    check("rst_fwd_ready", EXE_fwd_ready, 1'b1);
    check("rst_mem_valid", MEM_signal_valid, 1'b0);
    check("rst_mem_signal", MEM_signal, 71'd0);
    check("rst_fwd", EXE_fwd, 38'd0);
    check("rst_sram", {data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata}, 69'd0);
    check("rst_is_load", EXE_is_load, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("add", 0, 32'd5, 32'd7, 32'd12, 0);
    run_op("div", 15, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("mod", 17, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("divu0", 16, 32'h1234, 32'd0, 32'hFFFF_FFFF, 33);
    run_op("modu0", 18, 32'h1234, 32'd0, 32'h1234, 33);
    run_op("div_ovf", 15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    run_op("mod_ovf", 17, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
    run_op("mulh", 13, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 0);
    run_op("mulhu", 14, 32'h8000_0000, 32'd2, 32'h0000_0001, 0);

    // Store held by a 3-cycle downstream stall issues exactly one request.
    id_valid    = 1'b1;
    mem_allowin = 1'b0;
    exe_signal  = make_bundle(0, 32'h100, 32'd4, 32'h1C00_0080, 1'b0, 5'd0,
                              32'hCAFE_F00D, 1'b0, 4'hF);
    @(posedge clk); #1;
    id_valid = 1'b0;
    reqs = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("st_stall_en", data_sram_en, 1'b0);
      @(posedge clk); #1;
    end
    mem_allowin = 1'b1;
    @(negedge clk);
    check("st_we", data_sram_we, 4'hF);
    check("st_addr", data_sram_addr, 32'h104);
    check("st_wdata", data_sram_wdata, 32'hCAFE_F00D);
    for (int n = 0; n < 4; n++) begin
      if (data_sram_en) reqs++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    check("st_req_count", reqs, 1);
    @(posedge clk); #1;

    // Reset lands in the tenth BUSY cycle of a divide.
    id_valid   = 1'b1;
    exe_signal = make_bundle(15, 32'd100, 32'd3, 32'h1C00_00C0, 1'b1, 5'd9,
                             32'h0, 1'b0, 4'h0);
    @(posedge clk); #1;
    id_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    late_valid = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (MEM_signal_valid) late_valid++;
      @(posedge clk); #1;
    end
    check("abort_no_valid", late_valid, 0);
    check("abort_allowin", EXE_allowin, 1'b1);
    run_op("add_after_rst", 0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0);

    // Randomized traffic with random downstream back-pressure.
    for (int c = 0; c < 2000; c++) begin
      int opi;
      logic rfm;
      logic [3:0] mwe;
      opi = $urandom_range(0, 18);
      rfm = 1'b0;
      mwe = 4'h0;
      if (opi == 0 && $urandom_range(0, 2) == 0) begin
        rfm = $urandom_range(0, 1);
        mwe = $urandom_range(0, 15);
      end
      id_valid    = ($urandom_range(0, 3) != 0);
      mem_allowin = ($urandom_range(0, 9) < 8);
      exe_signal  = make_bundle(opi, pick_operand(), pick_operand(), $urandom,
                                $urandom_range(0, 1), $urandom_range(0, 31), $urandom, rfm, mwe);
      @(posedge clk); #1;
    end
    id_valid    = 1'b0;
    mem_allowin = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
